// File: rtl/vx_mem_arb_pkg.sv
// Shared types and constants for the local-memory arbiter slice.
// Defines the host-side FSM states, the requester identity used for
// grants and round-robin, and the default bus geometry.
package vx_mem_arb_pkg;

    localparam int ADDR_WIDTH     = 26;
    localparam int DATA_WIDTH     = 512;
    localparam int TAG_WIDTH      = 56;
    localparam int WORD_WIDTH     = 32;
    localparam int WORDS_PER_LINE = DATA_WIDTH / WORD_WIDTH;
    localparam int WORD_SEL_W     = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HREQ  = 2'd1,
        HRSP  = 2'd2,
        HDONE = 2'd3
    } host_state_t;

    typedef enum logic {
        CORE = 1'b0,
        HOST = 1'b1
    } grant_t;

endpackage

// File: rtl/generic_bus_if.sv
// Host generic bus (AHB-facing side).
// The host drives addr/ren/wen/wdata/byte_en and holds them while busy=1.
// The slave returns rdata and busy; rdata is valid in the cycle busy drops.
interface generic_bus_if;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        busy;

    modport generic_bus (
        input  addr, ren, wen, wdata, byte_en,
        output rdata, busy
    );

    modport cpu (
        output addr, ren, wen, wdata, byte_en,
        input  rdata, busy
    );
endinterface

// File: rtl/vx_host_word_adapter.sv
// Turns single 32-bit host accesses into line-wide memory requests and
// extracts the addressed word from the returning line.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   host_addr/ren/wen/wdata/byte_en  host access (held stable while busy)
//   host_rdata, host_busy       read word and busy back to the host
//   req_valid/rw/addr/data/byteen  line request toward the arbiter
//   req_fire                    request accepted by memory this cycle
//   rsp_valid, rsp_data         memory response already known to be host-tagged
module vx_host_word_adapter
    import vx_mem_arb_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = DATA_WIDTH,
    parameter int WW = WORD_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       host_addr,
    input  logic              host_ren,
    input  logic              host_wen,
    input  logic [WW-1:0]     host_wdata,
    input  logic [WW/8-1:0]   host_byte_en,
    output logic [WW-1:0]     host_rdata,
    output logic              host_busy,
    output logic              req_valid,
    output logic              req_rw,
    output logic [AW-1:0]     req_addr,
    output logic [DW-1:0]     req_data,
    output logic [DW/8-1:0]   req_byteen,
    input  logic              req_fire,
    input  logic              rsp_valid,
    input  logic [DW-1:0]     rsp_data
);

    localparam int WORDS = DW / WW;
    localparam int WSEL  = $clog2(WORDS);
    localparam int WB    = WW / 8;

    host_state_t state, next_state;
    logic [WSEL-1:0] word_sel;
    logic [1:0]      unused_addr_bits;

    assign word_sel         = host_addr[WSEL+1:2];
    assign unused_addr_bits = host_addr[1:0];

    // A write takes priority when the host raises both strobes.
    assign req_valid = (state == HREQ);
    assign req_rw    = host_wen;
    assign req_addr  = host_addr[AW+5:6];
    assign req_data  = {WORDS{host_wdata}};
    assign host_busy = (host_ren | host_wen) & (state != HDONE);

    // Only the addressed word lane is enabled; other lanes stay untouched.
    always_comb begin
        req_byteen = '0;
        req_byteen[word_sel*WB +: WB] = host_byte_en;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // HDONE is the single cycle in which busy is low and rdata is valid.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (host_ren | host_wen) next_state = HREQ;
            HREQ:  if (req_fire) next_state = host_wen ? HDONE : HRSP;
            HRSP:  if (rsp_valid) next_state = HDONE;
            HDONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Host-tagged responses arriving outside HRSP are stale and ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rdata <= '0;
        end else if (state == HRSP && rsp_valid) begin
            host_rdata <= rsp_data[word_sel*WW +: WW];
        end
    end

endmodule

// File: rtl/vx_local_mem_arbiter.sv
// Shares one line-wide local-memory port between the Vortex core and the
// host generic bus. Requests are arbitrated round-robin with a lock that
// holds a grant until memory accepts it; responses are routed back by the
// top bit of the memory tag (0 = core, 1 = host).
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   core_req_*/core_rsp_*  core line request/response channels
//   gbif                   host generic bus (slave side)
//   mem_req_*/mem_rsp_*    local memory request/response channels
module vx_local_mem_arbiter
    import vx_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = vx_mem_arb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = vx_mem_arb_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = vx_mem_arb_pkg::TAG_WIDTH,
    parameter int WORD_WIDTH = vx_mem_arb_pkg::WORD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_req_valid,
    input  logic                    core_req_rw,
    input  logic [DATA_WIDTH/8-1:0] core_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_data,
    input  logic [TAG_WIDTH-1:0]    core_req_tag,
    output logic                    core_req_ready,
    output logic                    core_rsp_valid,
    output logic [DATA_WIDTH-1:0]   core_rsp_data,
    output logic [TAG_WIDTH-1:0]    core_rsp_tag,
    input  logic                    core_rsp_ready,
    generic_bus_if.generic_bus      gbif,
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [TAG_WIDTH:0]      mem_req_tag,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [TAG_WIDTH:0]      mem_rsp_tag,
    output logic                    mem_rsp_ready
);

    logic                    host_req_valid;
    logic                    host_req_rw;
    logic [ADDR_WIDTH-1:0]   host_req_addr;
    logic [DATA_WIDTH-1:0]   host_req_data;
    logic [DATA_WIDTH/8-1:0] host_req_byteen;
    logic                    rsp_is_host;

    grant_t grant, rr_ptr, locked_grant;
    logic   lock;

    assign rsp_is_host = mem_rsp_tag[TAG_WIDTH];

    vx_host_word_adapter #(
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH),
        .WW (WORD_WIDTH)
    ) u_host (
        .clk          (clk),
        .reset        (reset),
        .host_addr    (gbif.addr),
        .host_ren     (gbif.ren),
        .host_wen     (gbif.wen),
        .host_wdata   (gbif.wdata),
        .host_byte_en (gbif.byte_en),
        .host_rdata   (gbif.rdata),
        .host_busy    (gbif.busy),
        .req_valid    (host_req_valid),
        .req_rw       (host_req_rw),
        .req_addr     (host_req_addr),
        .req_data     (host_req_data),
        .req_byteen   (host_req_byteen),
        .req_fire     (mem_req_ready && grant == HOST),
        .rsp_valid    (mem_rsp_valid && rsp_is_host),
        .rsp_data     (mem_rsp_data)
    );

    // A held grant wins; otherwise a lone requester is served immediately
    // and contention is settled by the round-robin pointer.
    always_comb begin
        grant = CORE;
        if (lock)
            grant = locked_grant;
        else if (core_req_valid && host_req_valid)
            grant = rr_ptr;
        else if (host_req_valid)
            grant = HOST;
    end

    assign mem_req_valid  = (grant == HOST) ? host_req_valid  : core_req_valid;
    assign mem_req_rw     = (grant == HOST) ? host_req_rw     : core_req_rw;
    assign mem_req_addr   = (grant == HOST) ? host_req_addr   : core_req_addr;
    assign mem_req_data   = (grant == HOST) ? host_req_data   : core_req_data;
    assign mem_req_byteen = (grant == HOST) ? host_req_byteen : core_req_byteen;
    assign mem_req_tag    = (grant == HOST) ? {1'b1, {TAG_WIDTH{1'b0}}}
                                            : {1'b0, core_req_tag};
    assign core_req_ready = mem_req_ready && (grant == CORE);

    // A stalled request locks the grant so memory sees stable valid/data;
    // every completed handshake hands priority to the other requester.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= CORE;
            lock         <= 1'b0;
            locked_grant <= CORE;
        end else if (mem_req_valid) begin
            if (mem_req_ready) begin
                lock   <= 1'b0;
                rr_ptr <= (grant == CORE) ? HOST : CORE;
            end else begin
                lock         <= 1'b1;
                locked_grant <= grant;
            end
        end
    end

    // The host side always sinks its responses, including stale ones.
    assign core_rsp_valid = mem_rsp_valid && !rsp_is_host;
    assign core_rsp_data  = mem_rsp_data;
    assign core_rsp_tag   = mem_rsp_tag[TAG_WIDTH-1:0];
    assign mem_rsp_ready  = rsp_is_host ? 1'b1 : core_rsp_ready;

endmodule

// File: tb/tb_vx_local_mem_arbiter.sv
module tb_vx_local_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         core_req_valid;
    logic         core_req_rw;
    logic [63:0]  core_req_byteen;
    logic [25:0]  core_req_addr;
    logic [511:0] core_req_data;
    logic [55:0]  core_req_tag;
    logic         core_req_ready;
    logic         core_rsp_valid;
    logic [511:0] core_rsp_data;
    logic [55:0]  core_rsp_tag;
    logic         core_rsp_ready;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [63:0]  mem_req_byteen;
    logic [25:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic [56:0]  mem_req_tag;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [511:0] mem_rsp_data;
    logic [56:0]  mem_rsp_tag;
    logic         mem_rsp_ready;

    int vectors    = 0;
    int miscompares = 0;

    logic [511:0] line_buf;

    generic_bus_if gbif_i ();

    vx_local_mem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .core_req_valid  (core_req_valid),
        .core_req_rw     (core_req_rw),
        .core_req_byteen (core_req_byteen),
        .core_req_addr   (core_req_addr),
        .core_req_data   (core_req_data),
        .core_req_tag    (core_req_tag),
        .core_req_ready  (core_req_ready),
        .core_rsp_valid  (core_rsp_valid),
        .core_rsp_data   (core_rsp_data),
        .core_rsp_tag    (core_rsp_tag),
        .core_rsp_ready  (core_rsp_ready),
        .gbif            (gbif_i),
        .mem_req_valid   (mem_req_valid),
        .mem_req_rw      (mem_req_rw),
        .mem_req_byteen  (mem_req_byteen),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_req_tag     (mem_req_tag),
        .mem_req_ready   (mem_req_ready),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .mem_rsp_tag     (mem_rsp_tag),
        .mem_rsp_ready   (mem_rsp_ready)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled mid-cycle, away from posedge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] byte_en);
        gbif_i.ren     = ren;
        gbif_i.wen     = wen;
        gbif_i.addr    = addr;
        gbif_i.wdata   = wdata;
        gbif_i.byte_en = byte_en;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Line whose word k holds 0xA000_0000+k, with one word overridden.
    function automatic logic [511:0] makeLine(input int word, input logic [31:0] value);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = 32'hA000_0000 + 32'(k);
        l[word*32 +: 32] = value;
        return l;
    endfunction

    initial begin
        logic [3:0] grant_exp;
        reset           = 1'b0;
        core_req_valid  = 1'b0;
        core_req_rw     = 1'b0;
        core_req_byteen = '0;
        core_req_addr   = '0;
        core_req_data   = '0;
        core_req_tag    = '0;
        core_rsp_ready  = 1'b0;
        mem_req_ready   = 1'b0;
        mem_rsp_valid   = 1'b0;
        mem_rsp_data    = '0;
        mem_rsp_tag     = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset state
        step(); #1;
        checkOutput("reset_mem_req_valid", 512'(mem_req_valid), 512'd0);
        checkOutput("reset_busy", 512'(gbif_i.busy), 512'd0);
        checkOutput("reset_rdata", 512'(gbif_i.rdata), 512'd0);
        reset = 1'b1;

        // Host write to 0x44
        step();
        applyStimulus(1'b0, 1'b1, 32'h0000_0044, 32'hDEADBEEF, 4'hF);
        mem_req_ready = 1'b1;
        #1;
        checkOutput("wr_busy_idle", 512'(gbif_i.busy), 512'd1);
        checkOutput("wr_no_req_idle", 512'(mem_req_valid), 512'd0);
        step(); #1;
        checkOutput("wr_req_valid", 512'(mem_req_valid), 512'd1);
        checkOutput("wr_req_rw", 512'(mem_req_rw), 512'd1);
        checkOutput("wr_req_addr", 512'(mem_req_addr), 512'h1);
        checkOutput("wr_req_byteen", 512'(mem_req_byteen), 512'h0000_0000_0000_00F0);
        checkOutput("wr_req_tag", 512'(mem_req_tag), {455'd0, 1'b1, 56'd0});
        checkOutput("wr_req_data_lo", 512'(mem_req_data[63:0]), 512'hDEADBEEF_DEADBEEF);
        checkOutput("wr_core_not_ready", 512'(core_req_ready), 512'd0);
        step(); #1;
        checkOutput("wr_busy_low", 512'(gbif_i.busy), 512'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Host read from 0x48 (word 2), memory answers 3 cycles later
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_0048, 32'h0, 4'hF);
        step(); #1;
        checkOutput("rd_req_valid", 512'(mem_req_valid), 512'd1);
        checkOutput("rd_req_rw", 512'(mem_req_rw), 512'd0);
        checkOutput("rd_req_addr", 512'(mem_req_addr), 512'h1);
        step(); #1;
        checkOutput("rd_wait_busy", 512'(gbif_i.busy), 512'd1);
        checkOutput("rd_wait_no_req", 512'(mem_req_valid), 512'd0);
        step();
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {1'b1, 56'd0};
        mem_rsp_data  = makeLine(2, 32'h12345678);
        #1;
        checkOutput("rd_rsp_ready", 512'(mem_rsp_ready), 512'd1);
        checkOutput("rd_rsp_not_core", 512'(core_rsp_valid), 512'd0);
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("rd_busy_low", 512'(gbif_i.busy), 512'd0);
        checkOutput("rd_rdata", 512'(gbif_i.rdata), 512'h12345678);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Core and host both requesting: grants alternate
        step();
        applyStimulus(1'b0, 1'b1, 32'h0000_0080, 32'h0BADF00D, 4'hF);
        core_req_valid = 1'b1;
        core_req_rw    = 1'b1;
        core_req_addr  = 26'h100;
        core_req_tag   = 56'h11;
        #1;
        checkOutput("rr_grant_0", 512'(mem_req_tag[56]), 512'd0);
        checkOutput("rr_core_ready_0", 512'(core_req_ready), 512'd1);
        grant_exp = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            checkOutput($sformatf("rr_grant_%0d", i + 1), 512'(mem_req_tag[56]),
                        512'(grant_exp[3 - i]));
            checkOutput($sformatf("rr_valid_%0d", i + 1), 512'(mem_req_valid), 512'd1);
        end
        step();
        core_req_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("rr_quiet", 512'(mem_req_valid), 512'd0);

        // Core stalled by memory while host arrives: grant locks on core
        step();
        mem_req_ready  = 1'b0;
        core_req_valid = 1'b1;
        core_req_rw    = 1'b0;
        core_req_addr  = 26'h2A5;
        core_req_data  = {16{32'h600DCAFE}};
        applyStimulus(1'b1, 1'b0, 32'h0000_0048, 32'h0, 4'hF);
        #1;
        checkOutput("lock_valid", 512'(mem_req_valid), 512'd1);
        checkOutput("lock_grant_0", 512'(mem_req_tag[56]), 512'd0);
        checkOutput("lock_core_stall", 512'(core_req_ready), 512'd0);
        for (int i = 1; i < 4; i++) begin
            step(); #1;
            checkOutput($sformatf("lock_grant_%0d", i), 512'(mem_req_tag[56]), 512'd0);
            checkOutput($sformatf("lock_addr_%0d", i), 512'(mem_req_addr), 512'h2A5);
        end
        step();
        mem_req_ready = 1'b1;
        #1;
        checkOutput("lock_release_ready", 512'(core_req_ready), 512'd1);
        checkOutput("lock_release_data", mem_req_data, {16{32'h600DCAFE}});
        step();
        core_req_valid = 1'b0;
        #1;
        checkOutput("lock_host_next_valid", 512'(mem_req_valid), 512'd1);
        checkOutput("lock_host_next_tag", 512'(mem_req_tag[56]), 512'd1);
        checkOutput("lock_host_next_addr", 512'(mem_req_addr), 512'h1);

        // Core response back-pressured, then host response sunk at once
        step();
        mem_rsp_valid  = 1'b1;
        mem_rsp_tag    = {1'b0, 56'h2A};
        mem_rsp_data   = makeLine(0, 32'h1111_2222);
        core_rsp_ready = 1'b0;
        #1;
        checkOutput("crsp_stall_ready", 512'(mem_rsp_ready), 512'd0);
        checkOutput("crsp_valid", 512'(core_rsp_valid), 512'd1);
        checkOutput("crsp_tag", 512'(core_rsp_tag), 512'h2A);
        step();
        core_rsp_ready = 1'b1;
        #1;
        checkOutput("crsp_accept_ready", 512'(mem_rsp_ready), 512'd1);
        step();
        mem_rsp_tag    = {1'b1, 56'd0};
        mem_rsp_data   = makeLine(2, 32'hCAFEF00D);
        core_rsp_ready = 1'b0;
        #1;
        checkOutput("hrsp_ready", 512'(mem_rsp_ready), 512'd1);
        checkOutput("hrsp_not_core", 512'(core_rsp_valid), 512'd0);
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("hrsp_busy_low", 512'(gbif_i.busy), 512'd0);
        checkOutput("hrsp_rdata", 512'(gbif_i.rdata), 512'hCAFEF00D);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset while waiting in HRSP
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_004C, 32'h0, 4'hF);
        step();
        step(); #1;
        checkOutput("rst_pre_busy", 512'(gbif_i.busy), 512'd1);
        reset = 1'b0;
        #1;
        checkOutput("rst_req_valid", 512'(mem_req_valid), 512'd0);
        checkOutput("rst_rdata_clear", 512'(gbif_i.rdata), 512'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {1'b1, 56'd0};
        mem_rsp_data  = makeLine(3, 32'h0000_55AA);
        #1;
        checkOutput("rst_late_ready", 512'(mem_rsp_ready), 512'd1);
        checkOutput("rst_late_not_core", 512'(core_rsp_valid), 512'd0);
        step();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("rst_late_rdata", 512'(gbif_i.rdata), 512'd0);
        checkOutput("rst_late_busy", 512'(gbif_i.busy), 512'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_004C, 32'h0, 4'hF);
        #1;
        checkOutput("rst_idle_no_req", 512'(mem_req_valid), 512'd0);
        step(); #1;
        checkOutput("rst_restart_req", 512'(mem_req_valid), 512'd1);
        checkOutput("rst_restart_tag", 512'(mem_req_tag[56]), 512'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
